// File: rtl/axis_video_pkg.sv
// Shared state type and size limit for the AXI4-Stream video line sender.
package axis_video_pkg;
  localparam int MAX_WIDTH = 8192;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    SEND,
    GAP,
    FIN
  } tx_state_e;
endpackage

// File: rtl/line_ram.sv
// Simple dual-port line buffer with a registered, enable-held read port.
module line_ram #(
  parameter int DW = 8,
  parameter int AW = 13
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/axis_line_tx.sv
// Streams frames of lines from a line buffer or a ramp pattern over AXI4-Stream.
module axis_line_tx
  import axis_video_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(MAX_WIDTH),
  parameter int LINE_GAP   = 0
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_arst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH:0]   line_width,
  input  logic [15:0]           num_lines,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_err,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [15:0] GAP_LAST =
    16'(LINE_GAP > 0 ? LINE_GAP - 1 : 0);

  tx_state_e st_q, st_d;
  logic [CW-1:0] w_q, ix_q;
  logic [15:0] l_q, iy_q, gap_q;
  logic mode_q, stop_q, wr_err_q;

  logic p_v_q, p_last_q, p_user_q, p_eof_q;
  logic [DATA_WIDTH-1:0] p_ramp_q, ram_rd, p_data;
  logic s_v_q, s_last_q, s_user_q, s_eof_q;
  logic [DATA_WIDTH-1:0] s_data_q;

  logic issue, pop, room, s_load;
  logic hd_last, hd_eof, pop_last, pop_eof;
  logic last_px, first_px, eof_px;
  logic [DATA_WIDTH-1:0] ramp;

  line_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_ram (
    .clk_i   (m_axis_aclk),
    .we_i    (wr_en && st_q == IDLE),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (issue),
    .raddr_i (ix_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_rd)
  );

  assign last_px  = ix_q == w_q - CW'(1);
  assign first_px = ix_q == '0 && iy_q == '0;
  assign eof_px   = last_px && iy_q == l_q - 16'd1;
  assign ramp     = DATA_WIDTH'(ix_q) + DATA_WIDTH'(iy_q);

  // Head of stream is the skid entry when full, else the RAM stage.
  assign p_data  = mode_q ? p_ramp_q : ram_rd;
  assign hd_last = s_v_q ? s_last_q : p_last_q;
  assign hd_eof  = s_v_q ? s_eof_q : p_eof_q;

  assign m_axis_tvalid = s_v_q | p_v_q;
  assign m_axis_tdata  = s_v_q ? s_data_q : p_data;
  assign m_axis_tlast  = m_axis_tvalid & hd_last;
  assign m_axis_tuser  =
    m_axis_tvalid & (s_v_q ? s_user_q : p_user_q);

  assign pop      = m_axis_tvalid & m_axis_tready;
  assign pop_last = pop & hd_last;
  assign pop_eof  = pop & hd_eof;
  assign room     = !s_v_q || pop || !p_v_q;
  assign s_load   = s_v_q ? pop : (p_v_q & ~pop & issue);

  assign busy   = st_q != IDLE;
  assign done   = st_q == FIN;
  assign wr_err = wr_err_q;

  always_comb begin
    st_d  = st_q;
    issue = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (start)
          st_d = (line_width == '0 || num_lines == '0)
                 ? FIN : PRIME;
      end
      PRIME: begin
        issue = 1'b1;
        st_d  = SEND;
      end
      SEND: begin
        issue = !stop_q && room;
        if (pop_eof) st_d = FIN;
        else if (pop_last && LINE_GAP != 0) st_d = GAP;
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          issue = 1'b1;
          st_d  = SEND;
        end
      end
      FIN: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_arst) begin
      st_q     <= IDLE;
      w_q      <= '0;
      l_q      <= '0;
      mode_q   <= 1'b0;
      ix_q     <= '0;
      iy_q     <= '0;
      gap_q    <= '0;
      stop_q   <= 1'b0;
      wr_err_q <= 1'b0;
      p_v_q    <= 1'b0;
      p_last_q <= 1'b0;
      p_user_q <= 1'b0;
      p_eof_q  <= 1'b0;
      p_ramp_q <= '0;
      s_v_q    <= 1'b0;
      s_last_q <= 1'b0;
      s_user_q <= 1'b0;
      s_eof_q  <= 1'b0;
      s_data_q <= '0;
    end else begin
      st_q     <= st_d;
      wr_err_q <= wr_en && st_q != IDLE;
      gap_q    <= (st_q == GAP) ? gap_q + 16'd1 : '0;
      if (st_q == IDLE && start) begin
        w_q    <= line_width;
        l_q    <= num_lines;
        mode_q <= mode;
        ix_q   <= '0;
        iy_q   <= '0;
        stop_q <= 1'b0;
      end
      if (st_q == GAP && issue) stop_q <= 1'b0;
      if (issue) begin
        p_ramp_q <= ramp;
        p_last_q <= last_px;
        p_user_q <= first_px;
        p_eof_q  <= eof_px;
        if (last_px) begin
          ix_q <= '0;
          if (eof_px) stop_q <= 1'b1;
          else begin
            iy_q <= iy_q + 16'd1;
            if (LINE_GAP != 0) stop_q <= 1'b1;
          end
        end else begin
          ix_q <= ix_q + CW'(1);
        end
      end
      p_v_q <= issue | (p_v_q & ~pop);
      if (s_load) begin
        s_v_q    <= p_v_q;
        s_data_q <= p_data;
        s_last_q <= p_last_q;
        s_user_q <= p_user_q;
        s_eof_q  <= p_eof_q;
      end
    end
  end
endmodule

// File: tb/tb_axis_line_tx.sv
// Directed bench for axis_line_tx: frames, ramps, gaps, write errors, reset.
module tb_axis_line_tx;
  localparam int DW = 8;
  localparam int AW = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst, wr_en, start, g_start, mode;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0] line_width;
  logic [15:0] num_lines;
  logic busy, done, wr_err, tvalid, tready, tlast, tuser;
  logic [DW-1:0] tdata;
  logic g_busy, g_done, g_wr_err, g_tvalid, g_tready, g_tlast, g_tuser;
  logic [DW-1:0] g_tdata;

  axis_line_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_GAP(0)) dut (
    .m_axis_aclk(clk), .m_axis_arst(arst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .mode(mode),
    .line_width(line_width), .num_lines(num_lines),
    .busy(busy), .done(done), .wr_err(wr_err),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast),
    .m_axis_tuser(tuser)
  );

  axis_line_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_GAP(3)) dut_g (
    .m_axis_aclk(clk), .m_axis_arst(arst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(g_start), .mode(mode),
    .line_width(line_width), .num_lines(num_lines),
    .busy(g_busy), .done(g_done), .wr_err(g_wr_err),
    .m_axis_tdata(g_tdata), .m_axis_tvalid(g_tvalid),
    .m_axis_tready(g_tready), .m_axis_tlast(g_tlast),
    .m_axis_tuser(g_tuser)
  );

  logic sel;
  logic o_valid, o_last, o_user, o_done, o_busy;
  logic [DW-1:0] o_data;
  assign o_valid = sel ? g_tvalid : tvalid;
  assign o_last  = sel ? g_tlast  : tlast;
  assign o_user  = sel ? g_tuser  : tuser;
  assign o_done  = sel ? g_done   : done;
  assign o_busy  = sel ? g_busy   : busy;
  assign o_data  = sel ? g_tdata  : tdata;

  int checks = 0;
  int errors = 0;

  int bd[$];
  bit bl[$];
  bit bu[$];
  int bc[$];
  int first_v, done_c, stall_bad;
  logic busy_post;

  // Collects transferred beats, done timing and stall-stability violations.
  task automatic capture(input int max_cyc, input bit rnd);
    bit pstall = 1'b0;
    bit rdy;
    logic [DW-1:0] pd = '0;
    logic pl = 1'b0, pu = 1'b0;
    bd.delete(); bl.delete(); bu.delete(); bc.delete();
    first_v = -1; done_c = -1; stall_bad = 0; busy_post = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (pstall && (o_valid !== 1'b1 || o_data !== pd ||
                     o_last !== pl || o_user !== pu))
        stall_bad++;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sel) g_tready = rdy; else tready = rdy;
      if (o_valid === 1'b1 && first_v < 0) first_v = c;
      if (o_valid === 1'b1 && rdy) begin
        bd.push_back(int'(o_data));
        bl.push_back(o_last);
        bu.push_back(o_user);
        bc.push_back(c);
      end
      pstall = (o_valid === 1'b1) && !rdy;
      pd = o_data; pl = o_last; pu = o_user;
      if (o_done === 1'b1) done_c = c;
      @(posedge clk); #1;
      if (done_c >= 0) begin
        busy_post = o_busy;
        break;
      end
    end
    tready = 1'b0;
    g_tready = 1'b0;
  endtask

  task automatic start_frame(input int w, input int l, input bit m,
                             input bit g);
    line_width = (AW+1)'(w);
    num_lines  = 16'(l);
    mode       = m;
    if (g) g_start = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    g_start = 1'b0;
  endtask

  task automatic load_buf();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_addr = AW'(i);
      wr_data = DW'(i);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_tvalid: got %b want 0", tvalid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: done %b wr_err %b want 0 0",
               done, wr_err);
    end
    checks++;
    if (tlast !== 1'b0 || tuser !== 1'b0) begin
      errors++;
      $display("FAIL reset_side: tlast %b tuser %b want 0 0",
               tlast, tuser);
    end
    arst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero(input int w, input int l);
    start_frame(w, l, 1'b0, 1'b0);
    capture(20, 1'b0);
    checks++;
    if (done_c !== 0) begin
      errors++; $display("FAIL zero_done: w %0d l %0d got cycle %0d want 0",
                         w, l, done_c);
    end
    checks++;
    if (first_v !== -1 || bd.size() !== 0) begin
      errors++; $display("FAIL zero_beats: got valid at %0d, %0d beats want none",
                         first_v, bd.size());
    end
    checks++;
    if (busy_post !== 1'b0) begin
      errors++; $display("FAIL zero_busy: got %b want 0", busy_post);
    end
  endtask

  task automatic test_mode0();
    start_frame(5, 2, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL m0_busy: got %b want 1", busy);
    end
    capture(60, 1'b0);
    checks++;
    if (bd.size() !== 10) begin
      errors++; $display("FAIL m0_count: got %0d want 10", bd.size());
    end
    for (int i = 0; i < bd.size() && i < 10; i++) begin
      checks++;
      if (bd[i] !== i % 5 || bl[i] !== (i % 5 == 4) || bu[i] !== (i == 0)) begin
        errors++;
        $display("FAIL m0_beat%0d: data %0d last %b user %b want %0d %b %b",
                 i, bd[i], bl[i], bu[i], i % 5, i % 5 == 4, i == 0);
      end
    end
    checks++;
    if (first_v !== 1) begin
      errors++; $display("FAIL m0_latency: got %0d want 1", first_v);
    end
    if (bc.size() == 10) begin
      checks++;
      if (done_c !== bc[9] + 1) begin
        errors++; $display("FAIL m0_done: got %0d want %0d", done_c, bc[9] + 1);
      end
      checks++;
      if (bc[5] !== bc[4] + 1) begin
        errors++; $display("FAIL m0_nobubble: got %0d want %0d", bc[5], bc[4] + 1);
      end
    end
    checks++;
    if (busy_post !== 1'b0) begin
      errors++; $display("FAIL m0_busy_end: got %b want 0", busy_post);
    end
  endtask

  task automatic test_ramp_random();
    int k = 0;
    start_frame(4, 3, 1'b1, 1'b0);
    capture(300, 1'b1);
    checks++;
    if (bd.size() !== 12) begin
      errors++; $display("FAIL rr_count: got %0d want 12", bd.size());
    end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) begin
        if (k < bd.size()) begin
          checks++;
          if (bd[k] !== x + y || bl[k] !== (x == 3) ||
              bu[k] !== (x == 0 && y == 0)) begin
            errors++;
            $display("FAIL rr_beat%0d: data %0d last %b user %b want %0d %b %b",
                     k, bd[k], bl[k], bu[k], x + y, x == 3, x == 0 && y == 0);
          end
        end
        k++;
      end
    checks++;
    if (stall_bad !== 0) begin
      errors++; $display("FAIL rr_stable: got %0d changes want 0", stall_bad);
    end
    checks++;
    if (done_c < 0 || busy_post !== 1'b0) begin
      errors++; $display("FAIL rr_done: done at %0d busy %b", done_c, busy_post);
    end
  endtask

  task automatic test_wrap();
    start_frame(260, 1, 1'b1, 1'b0);
    capture(400, 1'b0);
    checks++;
    if (bd.size() !== 260) begin
      errors++; $display("FAIL wrap_count: got %0d want 260", bd.size());
    end
    if (bd.size() == 260) begin
      checks++;
      if (bd[255] !== 255 || bd[256] !== 0 || bd[259] !== 3) begin
        errors++; $display("FAIL wrap_data: got %0d %0d %0d want 255 0 3",
                           bd[255], bd[256], bd[259]);
      end
      checks++;
      if (bl[258] !== 1'b0 || bl[259] !== 1'b1) begin
        errors++; $display("FAIL wrap_last: got %b %b want 0 1", bl[258], bl[259]);
      end
    end
  endtask

  task automatic test_w1();
    start_frame(1, 3, 1'b1, 1'b0);
    capture(40, 1'b0);
    checks++;
    if (bd.size() !== 3) begin
      errors++; $display("FAIL w1_count: got %0d want 3", bd.size());
    end
    for (int i = 0; i < bd.size() && i < 3; i++) begin
      checks++;
      if (bd[i] !== i || bl[i] !== 1'b1 || bu[i] !== (i == 0)) begin
        errors++; $display("FAIL w1_beat%0d: data %0d last %b user %b want %0d 1 %b",
                           i, bd[i], bl[i], bu[i], i, i == 0);
      end
    end
  endtask

  task automatic test_gap();
    sel = 1'b1;
    start_frame(2, 2, 1'b1, 1'b1);
    capture(60, 1'b0);
    sel = 1'b0;
    checks++;
    if (bd.size() !== 4) begin
      errors++; $display("FAIL gap_count: got %0d want 4", bd.size());
    end
    if (bd.size() == 4) begin
      checks++;
      if (bd[0] !== 0 || bd[1] !== 1 || bd[2] !== 1 || bd[3] !== 2) begin
        errors++; $display("FAIL gap_data: got %0d %0d %0d %0d want 0 1 1 2",
                           bd[0], bd[1], bd[2], bd[3]);
      end
      checks++;
      if (bc[2] - bc[1] - 1 !== 3) begin
        errors++; $display("FAIL gap_len: got %0d want 3", bc[2] - bc[1] - 1);
      end
      checks++;
      if (bc[1] !== bc[0] + 1) begin
        errors++; $display("FAIL gap_inline: got %0d want %0d", bc[1], bc[0] + 1);
      end
    end
  endtask

  task automatic test_wr_err();
    start_frame(5, 2, 1'b0, 1'b0);
    wr_en = 1'b1;
    wr_addr = AW'(2);
    wr_data = 8'hAA;
    @(posedge clk); #1;
    wr_en = 1'b0;
    checks++;
    if (wr_err !== 1'b1) begin
      errors++; $display("FAIL wrerr_pulse: got %b want 1", wr_err);
    end
    @(posedge clk); #1;
    checks++;
    if (wr_err !== 1'b0) begin
      errors++; $display("FAIL wrerr_clear: got %b want 0", wr_err);
    end
    capture(60, 1'b0);
    checks++;
    if (bd.size() !== 10) begin
      errors++; $display("FAIL wrerr_count: got %0d want 10", bd.size());
    end
    for (int i = 0; i < bd.size() && i < 10; i++) begin
      checks++;
      if (bd[i] !== i % 5) begin
        errors++; $display("FAIL wrerr_beat%0d: got %0d want %0d", i, bd[i], i % 5);
      end
    end
  endtask

  task automatic test_mid_reset();
    int pops = 0;
    start_frame(5, 2, 1'b0, 1'b0);
    for (int c = 0; c < 20 && pops < 3; c++) begin
      tready = 1'b1;
      if (tvalid === 1'b1) pops++;
      @(posedge clk); #1;
    end
    checks++;
    if (pops !== 3) begin
      errors++; $display("FAIL mrst_pops: got %0d want 3", pops);
    end
    tready = 1'b0;
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    checks++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mrst_state: tvalid %b busy %b want 0 0",
                         tvalid, busy);
    end
    checks++;
    if (done !== 1'b0 || wr_err !== 1'b0 || tlast !== 1'b0 || tuser !== 1'b0) begin
      errors++; $display("FAIL mrst_side: done %b wr_err %b tlast %b tuser %b want 0",
                         done, wr_err, tlast, tuser);
    end
    start_frame(5, 1, 1'b0, 1'b0);
    capture(40, 1'b0);
    checks++;
    if (bd.size() !== 5) begin
      errors++; $display("FAIL mrst_count: got %0d want 5", bd.size());
    end
    for (int i = 0; i < bd.size() && i < 5; i++) begin
      checks++;
      if (bd[i] !== i || bu[i] !== (i == 0) || bl[i] !== (i == 4)) begin
        errors++; $display("FAIL mrst_beat%0d: data %0d user %b last %b want %0d",
                           i, bd[i], bu[i], bl[i], i);
      end
    end
  endtask

  initial begin
    arst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; g_start = 1'b0; mode = 1'b0;
    line_width = '0; num_lines = '0;
    tready = 1'b0; g_tready = 1'b0; sel = 1'b0;
    test_reset();
    load_buf();
    test_zero(0, 3);
    test_zero(4, 0);
    test_mode0();
    test_ramp_random();
    test_wrap();
    test_w1();
    test_gap();
    test_wr_err();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
